// File: rtl/fifo_wr_flow_pkg.sv
// Shared FIFO pointer helpers: Gray<->binary conversion and pointer width.
// Latency: none (pure functions).
// Backpressure: n/a.
//
// Used by the FIFO write-flow and read-flow blocks. Functions operate on a
// fixed maximum width; callers zero-extend narrower Gray pointers, which
// converts correctly because leading Gray zeros map to leading binary zeros.
package fifo_wr_flow_pkg;

  localparam int PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  // Pointer width for a FIFO of the given depth: one extra wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_wr_flow_if.sv
// Write-flow bus: producer handshake, Gray pointers and write-side status.
// Latency: n/a (signal bundle).
// Backpressure: s_ready low while the FIFO is full.
//
// master: producer/FIFO-write-side view (drives s_valid, pointers, err_clr).
// slave : fifo_wr_flow view (drives s_ready, winc, rptr_sync, wcount,
//         walmost_full, werr).
interface fifo_wr_flow_if #(
  parameter int DEPTH = 8
);
  import fifo_wr_flow_pkg::*;

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0] rptr;          // Gray read pointer, read clock domain
  logic [PW-1:0] wptr;          // Gray write pointer, write clock domain
  logic          s_valid;
  logic          s_ready;
  logic          winc;
  logic          err_clr;
  logic [PW-1:0] rptr_sync;
  logic [PW-1:0] wcount;
  logic          walmost_full;
  logic          werr;

  modport master (
    output rptr, wptr, s_valid, err_clr,
    input  s_ready, winc, rptr_sync, wcount, walmost_full, werr
  );

  modport slave (
    input  rptr, wptr, s_valid, err_clr,
    output s_ready, winc, rptr_sync, wcount, walmost_full, werr
  );

endinterface

// File: rtl/fifo_wr_flow_sync2.sv
// Two-flop multi-bit synchroniser for Gray-coded pointers.
// Latency: 2 i_clk cycles from i_d to o_q.
// Backpressure: none; samples every cycle.
//
// Ports: i_clk (destination clock), i_rst_n (async active-low reset),
//        i_d (asynchronous input, Gray so only one bit moves at a time),
//        o_q (synchronised output).
module fifo_sync2 #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sync1;
  logic [W-1:0] r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
    end
  end

  assign o_q = r_sync2;

endmodule

// File: rtl/fifo_wr_flow.sv
// FIFO write-side flow control: full/ready, occupancy, almost-full, error.
// Latency: rptr->rptr_sync 2 cycles, rptr->wcount 3, wptr->wcount 1.
// Backpressure: s_ready drops combinationally when full; winc gated by it.
//
// Ports: wclk, wrst (async active-low), bus (fifo_wr_flow_if.slave):
//   in : rptr (async Gray), wptr (Gray), s_valid, err_clr
//   out: s_ready, winc, rptr_sync, wcount, walmost_full, werr
module fifo_wr_flow
  import fifo_wr_flow_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic            wclk,
  input  logic            wrst,
  fifo_wr_flow_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LVL);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_wr_flow: DEPTH must be a power of two >= 4");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("fifo_wr_flow: AFULL_LVL must be in 1..DEPTH");
  end

  logic [PW-1:0] w_rptr_sync;
  logic [PW-1:0] w_full_cmp;
  logic          w_full;
  ptr_t          w_wbin_ext;
  ptr_t          w_rbin_ext;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_occ;
  logic          w_err_set;
  logic          w_unused_hi;

  logic [PW-1:0] r_wcount;
  logic          r_walmost_full;
  logic          r_werr;

  fifo_sync2 #(.W(PW)) u_rptr_sync (
    .i_clk   (wclk),
    .i_rst_n (wrst),
    .i_d     (bus.rptr),
    .o_q     (w_rptr_sync)
  );

  // Full when the write pointer has lapped the read pointer exactly once:
  // in Gray code that is the top two bits inverted, the rest equal.
  assign w_full_cmp = {~w_rptr_sync[AW:AW-1], w_rptr_sync[AW-2:0]};
  assign w_full     = (bus.wptr == w_full_cmp);

  assign bus.s_ready = ~w_full;
  assign bus.winc    = bus.s_valid & ~w_full;

  assign w_wbin_ext = gray2bin(ptr_t'(bus.wptr));
  assign w_rbin_ext = gray2bin(ptr_t'(w_rptr_sync));
  assign w_wbin     = w_wbin_ext[PW-1:0];
  assign w_rbin     = w_rbin_ext[PW-1:0];
  // Upper bits are always zero for zero-extended inputs.
  assign w_unused_hi = ^{w_wbin_ext[PTR_MAX_W-1:PW], w_rbin_ext[PTR_MAX_W-1:PW]};

  // Modulo-2^PW subtraction handles pointer wrap. The read pointer lags by
  // the synchroniser, so this can only overstate occupancy.
  assign w_occ     = w_wbin - w_rbin;
  assign w_err_set = (w_occ > DEPTH_C);

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      r_wcount       <= '0;
      r_walmost_full <= 1'b0;
      r_werr         <= 1'b0;
    end else begin
      r_wcount       <= w_occ;
      // Derived from the same next value as r_wcount so both stay aligned.
      r_walmost_full <= (w_occ >= AFULL_C);
      // Set has priority over clear.
      r_werr         <= w_err_set | (r_werr & ~bus.err_clr);
    end
  end

  assign bus.rptr_sync    = w_rptr_sync;
  assign bus.wcount       = r_wcount;
  assign bus.walmost_full = r_walmost_full;
  assign bus.werr         = r_werr;

endmodule

// File: tb/tb_fifo_wr_flow.sv
// Directed self-checking bench for fifo_wr_flow (DEPTH=8, AFULL_LVL=6).
module tb_fifo_wr_flow;

  logic wclk = 1'b0;
  logic wrst;
  int   n_total = 0;
  int   n_pass  = 0;

  fifo_wr_flow_if #(.DEPTH(8)) bus ();

  fifo_wr_flow #(.DEPTH(8), .AFULL_LVL(6)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] g(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    // Reset with rptr=5 (Gray), wptr chosen so binary occupancy stays legal.
    wrst        = 1'b0;
    bus.rptr    = 4'd5;
    bus.wptr    = 4'd5;
    bus.s_valid = 1'b0;
    bus.err_clr = 1'b0;
    tick(); tick();
    chk("rst_rptr_sync", bus.rptr_sync, 0);
    chk("rst_wcount", bus.wcount, 0);
    chk("rst_werr", bus.werr, 0);
    chk("rst_afull", bus.walmost_full, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    bus.s_valid = 1'b1; #1;
    chk("rst_winc_follow", bus.winc, 1);
    bus.s_valid = 1'b0; #1;
    chk("rst_winc_idle", bus.winc, 0);
    wrst = 1'b1;
    tick();
    chk("rel_sync_edge1", bus.rptr_sync, 0);
    tick();
    chk("rel_sync_edge2", bus.rptr_sync, 5);
    tick();
    chk("rel_werr", bus.werr, 0);

    // Clean restart with both pointers at zero.
    wrst = 1'b0; bus.rptr = 4'd0; bus.wptr = 4'd0; #1;
    wrst = 1'b1;
    tick(); tick(); tick();
    chk("fill_start_wcount", bus.wcount, 0);

    // Fill: eight back-to-back writes, FIFO write side advances wptr.
    for (int i = 1; i <= 8; i++) begin
      bus.s_valid = 1'b1; #1;
      chk("fill_s_ready", bus.s_ready, 1);
      chk("fill_winc", bus.winc, 1);
      tick();
      bus.wptr = g(i); #1;
      chk("fill_wcount", bus.wcount, 32'(i - 1));
      chk("fill_afull", bus.walmost_full, (i - 1 >= 6) ? 1 : 0);
    end
    chk("full_s_ready", bus.s_ready, 0);
    chk("full_winc_9th", bus.winc, 0);
    tick();
    chk("full_wcount", bus.wcount, 8);
    chk("full_afull", bus.walmost_full, 1);
    chk("full_no_werr", bus.werr, 0);
    bus.s_valid = 1'b0;

    // Drain: read pointer advances by 3.
    bus.rptr = g(3);
    tick();
    chk("drain_edge1_ready", bus.s_ready, 0);
    tick();
    chk("drain_edge2_ready", bus.s_ready, 1);
    chk("drain_edge2_wcount", bus.wcount, 8);
    tick();
    chk("drain_wcount", bus.wcount, 5);
    chk("drain_afull", bus.walmost_full, 0);

    // Walk pointers to wbin=1, rbin=15 without passing an illegal occupancy.
    bus.rptr = g(8);
    tick(); tick(); tick();
    chk("wrap_empty8", bus.wcount, 0);
    bus.wptr = g(15);
    tick();
    chk("wrap_w15", bus.wcount, 7);
    bus.rptr = g(15);
    tick(); tick(); tick();
    chk("wrap_empty15", bus.wcount, 0);
    chk("wrap_rptr_sync", bus.rptr_sync, 32'(g(15)));
    bus.wptr = g(1);
    tick();
    chk("wrap_wcount", bus.wcount, 2);
    chk("wrap_werr", bus.werr, 0);

    // Error: occupancy 10 > DEPTH.
    bus.wptr = g(4);
    tick();
    bus.rptr = g(2);
    tick(); tick(); tick();
    chk("err_pre_wcount", bus.wcount, 2);
    chk("err_pre_werr", bus.werr, 0);
    bus.wptr = g(12);
    tick();
    chk("err_wcount", bus.wcount, 10);
    chk("err_set", bus.werr, 1);
    bus.wptr = g(4); bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_clr", bus.werr, 0);
    chk("err_clr_wcount", bus.wcount, 2);
    bus.wptr = g(12); bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0; bus.wptr = g(4);
    chk("err_set_wins", bus.werr, 1);
    tick();
    chk("err_sticky", bus.werr, 1);
    chk("err_sticky_wcount", bus.wcount, 2);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_clr2", bus.werr, 0);

    // Mid-operation asynchronous reset at wcount=4.
    bus.wptr = g(6);
    tick();
    chk("mid_wcount4", bus.wcount, 4);
    #2;
    wrst = 1'b0; #1;
    chk("mid_rst_wcount", bus.wcount, 0);
    chk("mid_rst_afull", bus.walmost_full, 0);
    chk("mid_rst_werr", bus.werr, 0);
    chk("mid_rst_sync", bus.rptr_sync, 0);
    chk("mid_rst_ready", bus.s_ready, 1);
    wrst = 1'b1;
    tick();
    chk("post_rst_wcount1", bus.wcount, 6);
    chk("post_rst_afull1", bus.walmost_full, 1);
    tick(); tick();
    chk("post_rst_sync", bus.rptr_sync, 32'(g(2)));
    chk("post_rst_wcount", bus.wcount, 4);
    chk("post_rst_werr", bus.werr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
